// File: rtl/seq_detect_pkg.sv
// ============================================================================
// Module  : seq_detect_pkg
// Brief   : Shared state encoding and default parameters for seq_detect_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_WIN_W   = 16;
  localparam int DEF_CNT_W   = 8;

  // One-hot, same style as the fixed-pattern detectors this block replaces.
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

endpackage

`default_nettype wire

// File: rtl/component_flop.sv
// ============================================================================
// Module  : component_flop
// Brief   : Enabled register with synchronous active-low reset to RST_VAL.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module component_flop #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (valid_in) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// ============================================================================
// Module  : seq_detect_ctrl
// Brief   : Run-time programmable serial pattern detector with window/stop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int WIN_W   = DEF_WIN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               stop,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               err
);

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [WIN_W-1:0]   r_window;
  logic [MAX_LEN-1:0] r_shift;
  logic [LEN_W-1:0]   r_fill;
  logic [WIN_W-1:0]   r_bits;

  logic               w_len_ok;
  logic               w_start_ok;
  logic               w_start_err;
  logic               w_run_bit;
  logic [MAX_LEN-1:0] w_shift_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [WIN_W-1:0]   w_bits_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_win_end;

  component_flop #(
    .WIDTH   (3),
    .RST_VAL (ST_IDLE)
  ) u_state_flop (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (1'b1),
    .d        (w_state_next),
    .q        (r_state)
  );

  assign w_len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_len_ok;
  assign w_start_err = start && !w_start_ok;
  // stop wins over a coincident valid bit
  assign w_run_bit   = (r_state == ST_RUN) && data_valid && !stop;

  assign w_shift_next = (r_shift << 1) | MAX_LEN'(data_in);
  assign w_fill_next  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_bits_next  = r_bits + WIN_W'(1);
  assign w_win_end    = (r_window != '0) && (w_bits_next == r_window);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_hit = (w_fill_next >= r_len) && ((w_shift_next & w_mask) == (r_pat & w_mask));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_state_next = ST_RUN;
      ST_RUN:           if (stop || (w_run_bit && w_win_end)) w_state_next = ST_DONE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      match       <= 1'b0;
      err         <= 1'b0;
      match_count <= '0;
      r_pat       <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_window    <= '0;
      r_shift     <= '0;
      r_fill      <= '0;
      r_bits      <= '0;
    end else begin
      busy  <= (w_state_next == ST_RUN);
      done  <= (w_state_next == ST_DONE);
      match <= 1'b0;
      err   <= w_start_err;
      if (w_start_ok) begin
        r_pat       <= cfg_pattern;
        r_len       <= cfg_len;
        r_overlap   <= cfg_overlap;
        r_window    <= cfg_window;
        r_shift     <= '0;
        r_fill      <= '0;
        r_bits      <= '0;
        match_count <= '0;
      end else if (w_run_bit) begin
        r_shift <= w_shift_next;
        r_fill  <= w_fill_next;
        r_bits  <= w_bits_next;
        if (w_hit) begin
          match <= 1'b1;
          if (match_count != '1) match_count <= match_count + CNT_W'(1);
          // non-overlap: the matched bits may not seed the next match
          if (!r_overlap) begin
            r_shift <= '0;
            r_fill  <= '0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// ============================================================================
// Module  : tb_seq_detect_ctrl
// Brief   : Scoreboard bench for seq_detect_ctrl (MAX_LEN=8, CNT_W=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int WIN_W   = 16;
  localparam int CNT_W   = 2;

  localparam int K_MATCH = 0;
  localparam int K_ERR   = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int kind;
    int cnt;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [WIN_W-1:0]   cfg_window = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               data_valid = 1'b0;
  logic               data_in = 1'b0;
  logic               busy, done, match, err;
  logic [CNT_W-1:0]   match_count;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  logic prev_done = 1'b0;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .WIN_W   (WIN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_window  (cfg_window),
    .start       (start),
    .stop        (stop),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .match_count (match_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check_ev(input int kind);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL evt_unexpected: got kind=%0d count=%0d, want no event", kind, match_count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != K_ERR && e.cnt != int'(match_count))) begin
        bad++;
        $display("FAIL evt: got kind=%0d count=%0d, want kind=%0d count=%0d",
                 kind, match_count, e.kind, e.cnt);
      end
    end
  endtask

  // Monitor: pops one expected event per observed output event
  always @(negedge clk) begin
    if (match) check_ev(K_MATCH);
    if (err) check_ev(K_ERR);
    if (done && !prev_done) check_ev(K_DONE);
    prev_done = done;
  end

  task automatic push(input int kind, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [MAX_LEN-1:0] pat, input int len, input logic ov,
                          input int win, input bit ok, input int hold_cnt);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ov;
    cfg_window  = WIN_W'(win);
    start       = 1'b1;
    if (!ok) push(K_ERR, 0);
    tick();
    start = 1'b0;
    cfg_pattern = '1;
    cfg_len     = LEN_W'(1);
    cfg_overlap = ~ov;
    cfg_window  = WIN_W'(1);
    if (ok) begin
      chk("start_busy", int'(busy), 1);
      chk("start_count", int'(match_count), 0);
    end else begin
      chk("rej_count", int'(match_count), hold_cnt);
    end
  endtask

  // exp_cnt < 0: no match expected on this bit
  task automatic send_bit(input logic b, input int exp_cnt, input bit last);
    data_valid = 1'b1;
    data_in    = b;
    if (exp_cnt >= 0) push(K_MATCH, exp_cnt);
    if (last) push(K_DONE, exp_cnt >= 0 ? exp_cnt : -1);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_stop(input int cnt, input logic dv);
    stop       = 1'b1;
    data_valid = dv;
    data_in    = 1'b1;
    push(K_DONE, cnt);
    tick();
    stop       = 1'b0;
    data_valid = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 1);
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_count", int'(match_count), 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    do_reset();

    // overlap: 1,0,1,0,1 matches at bits 3 and 5
    do_start(8'b101, 3, 1'b1, 0, 1'b1, 0);
    send_bit(1'b1, -1, 1'b0);
    send_bit(1'b0, -1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b0, -1, 1'b0);
    send_bit(1'b1, 2, 1'b0);
    do_stop(2, 1'b0);
    drain("drain_overlap");
    chk("hold_count", int'(match_count), 2);

    // non-overlap, straight from DONE: single match
    do_start(8'b101, 3, 1'b0, 0, 1'b1, 0);
    send_bit(1'b1, -1, 1'b0);
    send_bit(1'b0, -1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b0, -1, 1'b0);
    send_bit(1'b1, -1, 1'b0);
    do_stop(1, 1'b0);
    drain("drain_nonoverlap");

    // window 4 with a valid gap; bits after window end ignored
    do_start(8'b101, 3, 1'b1, 4, 1'b1, 0);
    send_bit(1'b1, -1, 1'b0);
    send_bit(1'b0, -1, 1'b0);
    tick();
    send_bit(1'b1, 1, 1'b0);
    data_valid = 1'b1;
    data_in    = 1'b1;
    push(K_DONE, 1);
    tick();
    data_valid = 1'b0;
    chk("win_done", int'(done), 1);
    send_bit(1'b0, -1, 1'b0);
    send_bit(1'b1, -1, 1'b0);
    drain("drain_window");
    chk("win_count", int'(match_count), 1);

    // saturation: len 1, window 5, five 1s, CNT_W=2
    do_start(8'b1, 1, 1'b1, 5, 1'b1, 0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b1, 3, 1'b0);
    send_bit(1'b1, 3, 1'b0);
    send_bit(1'b1, 3, 1'b1);
    drain("drain_sat");
    chk("sat_count", int'(match_count), 3);

    // illegal lengths from IDLE
    do_reset();
    do_start(8'b1, 0, 1'b1, 0, 1'b0, 0);
    chk("len0_busy", int'(busy), 0);
    chk("len0_done", int'(done), 0);
    do_start(8'b1, 9, 1'b1, 0, 1'b0, 0);
    chk("len9_busy", int'(busy), 0);
    drain("drain_badlen");

    // start while running is rejected and the run continues
    do_start(8'b11, 2, 1'b1, 0, 1'b1, 0);
    send_bit(1'b1, -1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    do_start(8'b0, 1, 1'b0, 2, 1'b0, 1);
    chk("runerr_busy", int'(busy), 1);
    send_bit(1'b1, 2, 1'b0);
    do_stop(2, 1'b0);
    drain("drain_runerr");

    // reset mid-run after two matches
    do_start(8'b1, 1, 1'b1, 0, 1'b1, 0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b1, 2, 1'b0);
    do_reset();
    drain("drain_rst");

    // stop beats a coincident completing bit
    do_start(8'b101, 3, 1'b1, 0, 1'b1, 0);
    send_bit(1'b1, -1, 1'b0);
    send_bit(1'b0, -1, 1'b0);
    do_stop(0, 1'b1);
    drain("drain_stopvalid");
    chk("stopvalid_count", int'(match_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial pattern-detection controller. Captures a pattern and length up to MAX_LEN bits, a run window and an overlap mode on a start command. It then sequences a bit-serial match datapath over a valid-qualified input stream, reporting per-match pulses and a saturating match count. It sits between the host/config logic and the serial input, replacing fixed-pattern detectors where the pattern must be chosen at run time.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥1)
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len
- WIN_W, 16: width of window counter
- CNT_W, 8: width of match counter
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is first bit received, bit 0 is last
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- cfg_window  in  WIN_W  number of valid bits to observe; 0 = unbounded (until stop)
- start  in  1  single-cycle command pulse
- stop  in  1  single-cycle abort/finish pulse
- data_valid  in  1  qualifies data_in
- data_in  in  1  serial data bit
- busy  out  1  high in RUN
- done  out  1  high in DONE (level)
- match  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  matches in current/last run, saturates at all-ones
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start with legal cfg_len: latch cfg_* into shadow registers, clear shift reg, fill count, bit count, match_count; go to RUN.
- start with cfg_len = 0 or > MAX_LEN: err pulse, state unchanged, counters unchanged.
- start in RUN: err pulse, ignored.
- RUN, data_valid=1, stop=0:
  - Shift data_in into LSB of shift reg (shift left).
  - Increment fill count (saturating at MAX_LEN) and bit count.
  - Match when post-shift fill ≥ len and post-shift shift reg masked to low len bits == masked pattern.
  - On match: match pulse; match_count+1, saturating at 2^CNT_W−1.
  - If non-overlap mode, clear shift reg and fill count after a match.
- RUN, data_valid=0: no shift, no count.
- Window end: cfg_window ≠ 0 and bit count reaches cfg_window on this bit. That bit is fully evaluated, then go to DONE.
- stop in RUN: go to DONE. Any data_valid in the same cycle is ignored (stop has priority). stop outside RUN is ignored.
- DONE holds match_count until the next accepted start. cfg_* changes outside an accepted start have no effect.
- Reset (rst_n=0 at edge): state IDLE; busy, done, match, err = 0; match_count = 0; shift reg and counters cleared. Reset mid-RUN aborts with no done.

## Timing
- All outputs are registered.
- start accepted at edge t: busy=1 from cycle t+1, done=0 from t+1, match_count=0 from t+1.
- First bit may be sampled at edge t+1.
- Bit sampled at edge k: match and updated match_count visible in cycle k+1. match lasts exactly one cycle.
- Last window bit or stop at edge k: busy=0, done=1 in cycle k+1. A match on the last bit is reported in the same cycle done rises.
- err asserted in the cycle after the offending start, for one cycle.
- Back-to-back start in DONE is legal. No idle cycle is required.

## Structure
- Shared package seq_detect_pkg holds:
  - State encoding localparams ST_IDLE/ST_RUN/ST_DONE (3-bit, matching the existing detector encoding style).
  - Default parameter values.
- State register: instantiate component_flop (WIDTH=3, valid_in tied 1). Shadow config, shift reg and counters are local registers.
- No other sub-module. The match compare stays combinational in-block.

## Test plan
- Pattern 3'b101, len 3, overlap, window 0, bits 1,0,1,0,1 then stop: match after 3rd and 5th bits, match_count=2, done=1 the cycle after stop.
- Same stream with cfg_overlap=0: single match after 3rd bit, match_count=1.
- Window 4, overlap, bits 1,0,1,1,0,1 with a data_valid=0 gap after bit 2: one match, done the cycle after 4th valid bit, bits 5–6 ignored, match_count=1.
- CNT_W=2, pattern 1'b1, len 1, window 5, five 1s: match pulses 5 times, match_count saturates at 3.
- start with cfg_len=0: err pulse, stays IDLE. Legal start, then start in RUN: err pulse, run continues, count unaffected.
- rst_n low mid-RUN after 2 matches: next cycle IDLE, all outputs 0. stop coincident with data_valid=1 completing a match: no match pulse, done=1 next cycle.
